// File: rtl/digital_timer_if.sv
// ----------------------------------------------------------------------------
// digital_timer_if
//   Load and status bundle between the mmu address decoder (master) and the
//   countdown timer peripheral (slave).
//
//   set_timer      master -> slave  one-cycle load strobe
//   timer_set_val  master -> slave  32-bit load value, valid with set_timer
//   timer_is_high  slave -> master  1 while the timer is running
//   timer_count    slave -> master  current registered count
//   timer_done     slave -> master  one-cycle expiry pulse
// ----------------------------------------------------------------------------
interface digital_timer_if;
  logic        set_timer;
  logic [31:0] timer_set_val;
  logic        timer_is_high;
  logic [31:0] timer_count;
  logic        timer_done;

  modport master (
    output set_timer,
    output timer_set_val,
    input  timer_is_high,
    input  timer_count,
    input  timer_done
  );

  modport slave (
    input  set_timer,
    input  timer_set_val,
    output timer_is_high,
    output timer_count,
    output timer_done
  );
endinterface

// File: rtl/digital_timer.sv
// ----------------------------------------------------------------------------
// digital_timer
//   Memory-mapped 32-bit countdown timer. A nonzero load starts a countdown
//   that decrements once every PRESCALE cycles. timer_is_high is held while
//   counting, and timer_done pulses for one cycle on each expiry. With
//   AUTO_RELOAD=1 the last loaded value is reloaded on expiry, which gives
//   periodic operation. Loading zero cancels the countdown.
//
//   Parameters
//     PRESCALE     clock cycles per decrement, 1..65536
//     AUTO_RELOAD  0 = one-shot, 1 = periodic
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          digital_timer_if.slave (load strobe/value in, status out)
// ----------------------------------------------------------------------------
module digital_timer #(
  parameter int unsigned PRESCALE    = 1,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  digital_timer_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   reload_q, reload_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;

    // A load takes priority over everything else, including an expiry that
    // falls on the same edge, so that expiry's pulse is dropped.
    if (bus.set_timer) begin
      pcnt_d = '0;
      if (bus.timer_set_val != 32'd0) begin
        count_d  = bus.timer_set_val;
        reload_d = bus.timer_set_val;
        state_d  = ST_RUN;
      end else begin
        count_d = 32'd0;
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_RUN) begin
      if (pcnt_q == PLAST) begin
        pcnt_d = '0;
        // In RUN the count is always >= 1, so it never wraps.
        if (count_q == 32'd1) begin
          done_d = 1'b1;
          if (AUTO_RELOAD) begin
            count_d = reload_q;
          end else begin
            count_d = 32'd0;
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q - 32'd1;
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 32'd0;
      reload_q <= 32'd0;
      pcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pcnt_q   <= pcnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.timer_is_high = (state_q == ST_RUN);
  assign bus.timer_count   = count_q;
  assign bus.timer_done    = done_q;

endmodule

// File: tb/tb_digital_timer.sv
module tb_digital_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // dut0: P=1 one-shot, dut1: P=4 one-shot, dut2: P=1 periodic
  digital_timer_if if0();
  digital_timer_if if1();
  digital_timer_if if2();

  digital_timer #(.PRESCALE(1), .AUTO_RELOAD(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  digital_timer #(.PRESCALE(4), .AUTO_RELOAD(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  digital_timer #(.PRESCALE(1), .AUTO_RELOAD(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        set;
    logic [31:0] val;
    logic        high;
    logic [31:0] cnt;
    logic        done;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic s, input logic [31:0] v);
    case (d)
      0: begin if0.set_timer = s; if0.timer_set_val = v; end
      1: begin if1.set_timer = s; if1.timer_set_val = v; end
      default: begin if2.set_timer = s; if2.timer_set_val = v; end
    endcase
  endtask

  task automatic get(input int d, output logic h, output logic [31:0] c, output logic dn);
    case (d)
      0: begin h = if0.timer_is_high; c = if0.timer_count; dn = if0.timer_done; end
      1: begin h = if1.timer_is_high; c = if1.timer_count; dn = if1.timer_done; end
      default: begin h = if2.timer_is_high; c = if2.timer_count; dn = if2.timer_done; end
    endcase
  endtask

  task automatic chk_dut(input int d, input string nm, input logic h, input logic [31:0] c, input logic dn);
    logic ah, adn;
    logic [31:0] ac;
    get(d, ah, ac, adn);
    chk($sformatf("%s_d%0d_high", nm, d), 32'(ah), 32'(h));
    chk($sformatf("%s_d%0d_count", nm, d), ac, c);
    chk($sformatf("%s_d%0d_done", nm, d), 32'(adn), 32'(dn));
  endtask

  // Reference model for the randomized phase: each running timer is
  // described only by its load edge and value; outputs follow from the
  // elapsed edge count with plain arithmetic.
  int  m_p  [3] = '{1, 4, 1};
  bit  m_ar [3] = '{1'b0, 1'b0, 1'b1};
  bit  m_run[3];
  int  m_k  [3];
  int  m_n  [3];

  initial begin
    int dones;
    logic h, dn;
    logic [31:0] c;

    tbl[0]  = '{1'b1, 32'd5,          1'b1, 32'd5,          1'b0};
    tbl[1]  = '{1'b0, 32'd0,          1'b1, 32'd4,          1'b0};
    tbl[2]  = '{1'b0, 32'd0,          1'b1, 32'd3,          1'b0};
    tbl[3]  = '{1'b0, 32'd0,          1'b1, 32'd2,          1'b0};
    tbl[4]  = '{1'b0, 32'd0,          1'b1, 32'd1,          1'b0};
    tbl[5]  = '{1'b0, 32'd0,          1'b0, 32'd0,          1'b1};
    tbl[6]  = '{1'b0, 32'd0,          1'b0, 32'd0,          1'b0};
    tbl[7]  = '{1'b1, 32'd0,          1'b0, 32'd0,          1'b0};
    tbl[8]  = '{1'b1, 32'd2,          1'b1, 32'd2,          1'b0};
    tbl[9]  = '{1'b0, 32'd0,          1'b1, 32'd1,          1'b0};
    tbl[10] = '{1'b1, 32'd3,          1'b1, 32'd3,          1'b0};
    tbl[11] = '{1'b0, 32'd0,          1'b1, 32'd2,          1'b0};
    tbl[12] = '{1'b1, 32'd0,          1'b0, 32'd0,          1'b0};
    tbl[13] = '{1'b0, 32'd0,          1'b0, 32'd0,          1'b0};
    tbl[14] = '{1'b1, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b0};
    tbl[15] = '{1'b0, 32'd0,          1'b1, 32'hFFFF_FFFE,  1'b0};
    tbl[16] = '{1'b1, 32'd0,          1'b0, 32'd0,          1'b0};

    for (int d = 0; d < 3; d++) drv(d, 1'b0, 32'd0);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_dut(d, "reset", 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) chk_dut(d, "post_reset", 1'b0, 32'd0, 1'b0);
    $display("reset: all timers idle");

    // Table-driven sequence on the P=1 one-shot timer
    for (int i = 0; i < 17; i++) begin
      drv(0, tbl[i].set, tbl[i].val);
      tick();
      chk_dut(0, $sformatf("tbl%0d", i), tbl[i].high, tbl[i].cnt, tbl[i].done);
      $display("tbl row %0d set=%0d val=%h -> high=%0d count=%h done=%0d",
               i, tbl[i].set, tbl[i].val, if0.timer_is_high, if0.timer_count, if0.timer_done);
    end
    drv(0, 1'b0, 32'd0);
    tick();

    // P=4, N=3 one-shot: 12 cycles high, decrement every 4th edge, one pulse
    drv(1, 1'b1, 32'd3);
    tick();
    drv(1, 1'b0, 32'd0);
    chk_dut(1, "p4_load", 1'b1, 32'd3, 1'b0);
    dones = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      get(1, h, c, dn);
      if (dn) dones++;
      chk_dut(1, $sformatf("p4_e%0d", e), e < 12, (e < 12) ? 32'(3 - e / 4) : 32'd0, e == 12);
    end
    chk("p4_pulse_count", 32'(dones), 32'd1);
    $display("p4 one-shot N=3: %0d done pulse(s)", dones);

    // Periodic P=1, N=4: pulses every 4 edges, count 4,3,2,1,4,...
    drv(2, 1'b1, 32'd4);
    tick();
    drv(2, 1'b0, 32'd0);
    chk_dut(2, "ar_load", 1'b1, 32'd4, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      tick();
      chk_dut(2, $sformatf("ar_e%0d", e), 1'b1, 32'(4 - e % 4), (e % 4) == 0);
    end
    $display("periodic N=4: 13 edges checked");

    // Collision on the periodic timer: load 7 on an expiry edge
    drv(2, 1'b1, 32'd4);
    tick();
    drv(2, 1'b0, 32'd0);
    tick(); tick(); tick();
    drv(2, 1'b1, 32'd7);
    tick();
    drv(2, 1'b0, 32'd0);
    chk_dut(2, "collide", 1'b1, 32'd7, 1'b0);
    tick();
    chk_dut(2, "collide_next", 1'b1, 32'd6, 1'b0);
    drv(2, 1'b1, 32'd0);
    tick();
    drv(2, 1'b0, 32'd0);
    chk_dut(2, "ar_cancel", 1'b0, 32'd0, 1'b0);
    $display("collision load 7 on expiry edge, then cancel");

    // Restart: load 10, reload 3 at +5, expiry at +8, none at +10
    drv(0, 1'b1, 32'd10);
    tick();
    for (int e = 1; e <= 12; e++) begin
      drv(0, e == 5, 32'd3);
      tick();
      get(0, h, c, dn);
      chk($sformatf("restart_e%0d_done", e), 32'(dn), 32'(e == 8));
      chk($sformatf("restart_e%0d_high", e), 32'(h), 32'(e < 8));
      if (e == 5) chk("restart_count", c, 32'd3);
    end
    drv(0, 1'b0, 32'd0);
    $display("restart 10 -> 3 at +5");

    // Asynchronous reset mid-count
    drv(0, 1'b1, 32'h1234);
    drv(2, 1'b1, 32'd9);
    tick();
    drv(0, 1'b0, 32'd0);
    drv(2, 1'b0, 32'd0);
    chk("rst_pre_count", if0.timer_count, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_dut(d, "async_rst", 1'b0, 32'd0, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    tick(); tick(); tick();
    for (int d = 0; d < 3; d++) chk_dut(d, "after_rst", 1'b0, 32'd0, 1'b0);
    $display("async reset mid-count at 0x1234");

    // Randomized phase against the reference model
    for (int d = 0; d < 3; d++) m_run[d] = 1'b0;
    for (int t = 0; t < 400; t++) begin
      logic s;
      logic [31:0] v;
      s = ($urandom % 7) == 0;
      v = (($urandom % 5) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
      for (int d = 0; d < 3; d++) drv(d, s, v);
      tick();
      if (s) $display("rand t=%0d load %0d", t, v);
      for (int d = 0; d < 3; d++) begin
        logic eh, ed;
        logic [31:0] ec;
        eh = 1'b0; ed = 1'b0; ec = 32'd0;
        if (s) begin
          m_run[d] = (v != 0);
          m_k[d] = t;
          m_n[d] = int'(v);
          eh = (v != 0);
          ec = v;
        end else if (m_run[d]) begin
          int e, per;
          e = t - m_k[d];
          per = m_n[d] * m_p[d];
          if (m_ar[d]) begin
            eh = 1'b1;
            ed = (e % per) == 0;
            ec = 32'(m_n[d] - (e % per) / m_p[d]);
          end else if (e == per) begin
            m_run[d] = 1'b0;
            ed = 1'b1;
          end else begin
            eh = 1'b1;
            ec = 32'(m_n[d] - e / m_p[d]);
          end
        end
        chk_dut(d, $sformatf("rand_t%0d", t), eh, ec, ed);
      end
    end
    for (int d = 0; d < 3; d++) drv(d, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digital_timer.md
# digital_timer

Memory-mapped countdown timer on the peripheral side of the `mmu` address decoder at address 0x10. It receives load commands from `mmu` through `set_timer`/`timer_set_val` and reports its state back through `timer_is_high`. It counts down a 32-bit value at a prescaled rate, holds `timer_is_high` while counting, and emits a one-cycle expiry pulse. Optionally, it auto-reloads for periodic operation.

## Interface
- `PRESCALE`, default 1: clock cycles per count decrement. Legal range 1..65536.
- `AUTO_RELOAD`, default 0: 0 selects one-shot mode; 1 selects periodic reload of the last loaded value.
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `set_timer`, input, 1: one-cycle load strobe from `mmu`.
- `timer_set_val`, input, 32: load value, sampled when `set_timer`=1.
- `timer_is_high`, output, 1: high while the timer is running (state RUN).
- `timer_count`, output, 32: current count value, registered.
- `timer_done`, output, 1: one-cycle pulse on each expiry, registered.

## Operation
- Internal registers:
  - `count` (32 bits).
  - `reload` (32 bits): holds the last nonzero load value.
  - `pcnt` (prescaler, width `$clog2(PRESCALE)`, minimum 1 bit).
  - state register: IDLE or RUN.
- Reset (`rst_n`=0, asynchronous) forces: state=IDLE, `count`=0, `reload`=0, `pcnt`=0, `timer_is_high`=0, `timer_done`=0. All outputs read 0 while reset is asserted.
- IDLE:
  - `set_timer`=1 with `timer_set_val`=N≠0: `count`←N, `reload`←N, `pcnt`←0, go to RUN.
  - `set_timer`=1 with N=0: stay in IDLE, no `timer_done`.
- RUN:
  - Each cycle `pcnt` increments. When `pcnt`=PRESCALE-1, `pcnt`←0 and `count`←`count`-1.
  - The decrement that takes `count` from 1 to 0 is the expiry event:
    - `AUTO_RELOAD`=0: go to IDLE with `count`=0, and `timer_done`=1 for that one cycle.
    - `AUTO_RELOAD`=1: `count`←`reload`, stay in RUN, and `timer_done`=1 for that one cycle. `timer_is_high` stays 1.
  - `set_timer`=1 with N≠0: restart. `count`←N, `reload`←N, `pcnt`←0, stay in RUN.
  - `set_timer`=1 with N=0: cancel. Go to IDLE, `count`←0, no `timer_done`.
- Priority: `set_timer` overrides expiry in the same cycle. A reload or cancel arriving on the expiry cycle suppresses the `timer_done` pulse.
- `count` never wraps below 0. Decrementing only happens in RUN, where `count`≥1.
- `timer_is_high` is 1 exactly when state=RUN. It is driven from a register, with no combinational path from the inputs.

## Timing
- Load latency: with `set_timer` sampled at edge k (value N, PRESCALE=P), the following hold from edge k onward: `timer_is_high`=1, `timer_count`=N.
- One-shot: `timer_is_high` stays high for exactly N·P cycles. At edge k+N·P:
  - `timer_is_high`←0
  - `timer_count`←0
  - `timer_done`←1, which returns to 0 at edge k+N·P+1.
- `timer_count` steps down by 1 every P cycles. The first decrement is visible at edge k+P.
- Periodic: `timer_done` pulses at edges k+N·P, k+2N·P, and so on. The period is exactly N·P cycles with no dead cycle. `timer_count` reads N in the same cycle that `timer_done`=1.
- A restart at edge j discards the partial prescale. The next expiry is at j+N·P.
- Maximum N=0xFFFFFFFF. No overflow is possible.
- Reset assertion mid-count takes effect immediately (asynchronously). After `rst_n` is released, the block is idle until the next `set_timer`.

## Test plan
- Reset, then a one-shot load with P=1, N=5 at edge 10 → `timer_is_high`=1 over edges 10..14, `timer_count` steps 5,4,3,2,1, at edge 15 `timer_is_high`=0, `timer_count`=0, `timer_done`=1 for one cycle.
- P=4, N=3 → `timer_is_high` high for 12 cycles, `timer_count` decrements every 4th edge, exactly one `timer_done` pulse.
- `AUTO_RELOAD`=1, P=1, N=4 → `timer_done` at edges +4, +8, +12, `timer_is_high` continuously 1, `timer_count` cycles 4,3,2,1,4,…
- Restart and cancel:
  - Load N=10, then `set_timer` with N=3 at edge +5 → expiry 3 cycles later, with no pulse at the original +10.
  - Load N=0 during RUN → immediately IDLE, no `timer_done`.
- Collision: `set_timer` (N=7) on the same edge as expiry → no `timer_done`, `timer_count`=7, timer still running.
- Assert `rst_n`=0 mid-count (`timer_count`=0x1234) → all outputs 0 without waiting for a clock edge, and they remain 0 after release until the next load.
